am_insert_tx: RTL and testbench

Per-lane alignment marker inserter for the 40GBASE-R transmit PCS, mirroring the receive-side marker lock. It sits between the scrambler and the TX gearbox. Every 16384 valid block slots it replaces one slot with the lane's alignment marker, carrying a BIP3/BIP7 computed over all blocks since the previous marker. While the marker occupies the slot it back-pressures the upstream block source.

---
 rtl/am_pkg.sv | 36 +++
 rtl/am_insert_tx_if.sv | 33 +++
 rtl/am_bip_acc.sv | 54 +++++
 rtl/am_insert_tx.sv | 93 +++++++++
 tb/tb_am_insert_tx.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/am_pkg.sv
// -----------------------------------------------------------------------------
// am_pkg
// Constants shared by the 40GBASE-R alignment marker inserter (TX) and the
// marker lock (RX).
//   SYNC_CTRL / SYNC_DATA : 2-bit sync header values, block bits [1:0]
//   GAP_N                 : data blocks between consecutive markers
//   CNT_W                 : width of the marker slot counter
//   AM_M                  : per-lane M-bytes, packed {M0,M1,M2,M4,M5,M6}
//   am_marker()           : builds a 66-bit marker from lane index and BIP3
// -----------------------------------------------------------------------------
package am_pkg;

  localparam logic [1:0] SYNC_CTRL = 2'b10;
  localparam logic [1:0] SYNC_DATA = 2'b01;

  localparam int GAP_N = 16383;
  localparam int CNT_W = 14;

  // Read left to right in transmission order: M0 M1 M2 M4 M5 M6.
  localparam logic [47:0] AM_M [0:3] = '{
    48'h907647_6f89b8,
    48'hf0c4e6_0f3b19,
    48'hc5659b_3a9a64,
    48'ha2793d_5d86c2
  };

  // Layout LSB first: sync, M0, M1, M2, BIP3, M4, M5, M6, BIP7 (= ~BIP3).
  function automatic logic [65:0] am_marker(input logic [1:0] lane,
                                            input logic [7:0] bip3);
    logic [47:0] m;
    m = AM_M[lane];
    return {~bip3, m[7:0], m[15:8], m[23:16], bip3,
            m[31:24], m[39:32], m[47:40], SYNC_CTRL};
  endfunction

endpackage

// File: rtl/am_insert_tx_if.sv
// -----------------------------------------------------------------------------
// am_insert_tx_if
// Block bus between the scrambler/gearbox and the alignment marker inserter.
//   valid_i : slot enable from the gearbox
//   block_i : scrambled block from upstream
//   ready_o : block_i consumed this slot (low = marker takes the slot)
//   valid_o : block_o valid
//   am_v_o  : block_o is an alignment marker
//   block_o : block towards the gearbox
// Modports: slave = inserter side, master = driving side.
// -----------------------------------------------------------------------------
interface am_insert_tx_if #(
  parameter int BLOCK_W = 66
);

  logic               valid_i;
  logic [BLOCK_W-1:0] block_i;
  logic               ready_o;
  logic               valid_o;
  logic               am_v_o;
  logic [BLOCK_W-1:0] block_o;

  modport slave (
    input  valid_i, block_i,
    output ready_o, valid_o, am_v_o, block_o
  );

  modport master (
    output valid_i, block_i,
    input  ready_o, valid_o, am_v_o, block_o
  );

endinterface

// File: rtl/am_bip_acc.sv
// -----------------------------------------------------------------------------
// am_bip_acc
// Bit-interleaved parity accumulator for the alignment marker BIP3 field.
// Only built when AM_TX_BIP_EN is defined.
//   clk, reset : clock, asynchronous active-high reset
//   en_i       : slot is valid; nothing changes when low
//   load_i     : slot carries a marker; reload instead of accumulate
//   block_i    : block emitted in this slot
//   bip_o      : accumulated parity (the BIP3 of the next marker)
// Parity: XOR of the 8 payload bytes, sync bit 0 folded into bit 3 and
// sync bit 1 folded into bit 4.
// -----------------------------------------------------------------------------
`ifdef AM_TX_BIP_EN
module am_bip_acc #(
  parameter int BLOCK_W = 66
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic               load_i,
  input  logic [BLOCK_W-1:0] block_i,
  output logic [7:0]         bip_o
);

  logic [7:0] par_chain [0:8];
  logic [7:0] acc_q, acc_d;

  // Chain starts from the folded sync bits, then XORs in each payload byte.
  assign par_chain[0] = {3'b000, block_i[1], block_i[0], 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte
      assign par_chain[gi+1] = par_chain[gi] ^ block_i[2 + 8*gi +: 8];
    end
  endgenerate

  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      if (load_i) acc_d = par_chain[8];
      else        acc_d = acc_q ^ par_chain[8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign bip_o = acc_q;

endmodule
`endif

// File: rtl/am_insert_tx.sv
// -----------------------------------------------------------------------------
// am_insert_tx
// Per-lane alignment marker inserter for the 40GBASE-R TX PCS. Every
// GAP_N+1 valid slots one slot carries the lane's alignment marker instead
// of upstream data; upstream is held off (ready_o low) for that slot.
//   clk     : clock
//   reset   : asynchronous active-high reset
//   bus     : am_insert_tx_if.slave (valid_i, block_i, ready_o, valid_o,
//             am_v_o, block_o)
// Build option: AM_TX_BIP_EN -- when defined the BIP accumulator is built and
// markers carry a real BIP3/BIP7; otherwise markers carry BIP3=00, BIP7=ff.
// -----------------------------------------------------------------------------
module am_insert_tx #(
  parameter int BLOCK_W = 66,
  parameter int LANE_N  = 4,
  parameter int LANE    = 0,
  parameter int GAP_N   = am_pkg::GAP_N
) (
  input  logic          clk,
  input  logic          reset,
  am_insert_tx_if.slave bus
);

  import am_pkg::*;

  localparam logic [1:0]       LANE_SEL = 2'(LANE % LANE_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_N);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic               valid_q;
  logic               am_v_q, am_v_d;
  logic [7:0]         bip3;
  logic [65:0]        marker;

  // Counter value 0 is the marker slot. It only advances on valid slots, so
  // a marker slot missed while valid_i is low is simply deferred.
  assign bus.ready_o = (cnt_q != '0);

  assign marker = am_marker(LANE_SEL, bip3);

  always_comb begin
    cnt_d   = cnt_q;
    block_d = block_q;
    am_v_d  = am_v_q;
    if (bus.valid_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (bus.ready_o) begin
        block_d = bus.block_i;
        am_v_d  = 1'b0;
      end else begin
        block_d = marker;
        am_v_d  = 1'b1;
      end
    end
  end

`ifdef AM_TX_BIP_EN
  // The accumulator sees exactly the emitted block, so a marker slot reloads
  // it with the parity of the marker including its final BIP fields.
  am_bip_acc #(
    .BLOCK_W (BLOCK_W)
  ) u_bip_acc (
    .clk     (clk),
    .reset   (reset),
    .en_i    (bus.valid_i),
    .load_i  (~bus.ready_o),
    .block_i (block_d),
    .bip_o   (bip3)
  );
`else
  assign bip3 = 8'h00;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      block_q <= '0;
      valid_q <= 1'b0;
      am_v_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      block_q <= block_d;
      valid_q <= bus.valid_i;
      am_v_q  <= am_v_d;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.am_v_o  = am_v_q;
  assign bus.block_o = block_q;

endmodule

// File: tb/tb_am_insert_tx.sv
// -----------------------------------------------------------------------------
// tb_am_insert_tx
// Self-checking bench for am_insert_tx (LANE=0 main instance, LANE=2 second
// instance). A reference model tracks "marker pending" and the data count
// since the last marker, and computes BIP from the bit-interleave rule.
// -----------------------------------------------------------------------------
module tb_am_insert_tx;

  localparam int GAP = 16383;
`ifdef AM_TX_BIP_EN
  localparam bit BIP_EN = 1'b1;
`else
  localparam bit BIP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic rst2;

  always #5 clk = ~clk;

  am_insert_tx_if #(.BLOCK_W(66)) ifc ();
  am_insert_tx_if #(.BLOCK_W(66)) ifc2 ();

  am_insert_tx #(.BLOCK_W(66), .LANE_N(4), .LANE(0), .GAP_N(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  am_insert_tx #(.BLOCK_W(66), .LANE_N(4), .LANE(2), .GAP_N(GAP)) dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (ifc2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model (lane 0) ----------------
  bit          m_pending;
  int          m_data_since;
  logic [7:0]  m_acc;
  logic        exp_valid;
  logic        exp_am;
  logic [65:0] exp_blk;

  // BIP bit j covers block bits k>=2 with k mod 8 == (j+2) mod 8,
  // plus sync bit 0 into bit 3 and sync bit 1 into bit 4.
  function automatic logic [7:0] bip_of(input logic [65:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 2; k < 66; k++) begin
      for (int j = 0; j < 8; j++) begin
        if ((k % 8) == ((j + 2) % 8)) r[j] = r[j] ^ b[k];
      end
    end
    r[3] = r[3] ^ b[0];
    r[4] = r[4] ^ b[1];
    return r;
  endfunction

  function automatic logic [65:0] mk_marker(input int lane, input logic [7:0] b3);
    logic [7:0]  pb [8];
    logic [65:0] r;
    case (lane)
      0:       pb = '{8'h90, 8'h76, 8'h47, 8'h00, 8'h6f, 8'h89, 8'hb8, 8'h00};
      1:       pb = '{8'hf0, 8'hc4, 8'he6, 8'h00, 8'h0f, 8'h3b, 8'h19, 8'h00};
      2:       pb = '{8'hc5, 8'h65, 8'h9b, 8'h00, 8'h3a, 8'h9a, 8'h64, 8'h00};
      default: pb = '{8'ha2, 8'h79, 8'h3d, 8'h00, 8'h5d, 8'h86, 8'hc2, 8'h00};
    endcase
    pb[3] = b3;
    pb[7] = ~b3;
    r = '0;
    r[1:0] = 2'b10;
    for (int i = 0; i < 8; i++) r[2 + 8*i +: 8] = pb[i];
    return r;
  endfunction

  task automatic model_reset();
    m_pending    = 1'b1;
    m_data_since = 0;
    m_acc        = 8'h00;
    exp_valid    = 1'b0;
    exp_am       = 1'b0;
    exp_blk      = '0;
  endtask

  task automatic model_step(input logic v, input logic [65:0] blk);
    exp_valid = v;
    if (v) begin
      if (m_pending) begin
        exp_blk      = mk_marker(0, BIP_EN ? m_acc : 8'h00);
        exp_am       = 1'b1;
        m_acc        = bip_of(exp_blk);
        m_pending    = 1'b0;
        m_data_since = 0;
      end else begin
        exp_blk      = blk;
        exp_am       = 1'b0;
        m_acc        = m_acc ^ bip_of(blk);
        m_data_since = m_data_since + 1;
        if (m_data_since == GAP) m_pending = 1'b1;
      end
    end
  endtask

  function automatic logic [65:0] rand_blk();
    logic [65:0] r;
    r = {$urandom, $urandom, 2'($urandom_range(1, 2))};
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    ifc.valid_i = 1'b0;
    ifc.block_i = '0;
    model_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({ifc.valid_o, ifc.am_v_o, ifc.block_o} !== 68'h0)
      $display("FAIL reset_outputs got v=%b am=%b blk=%h want 0", ifc.valid_o, ifc.am_v_o, ifc.block_o);
    else n_pass++;
    n_checks++;
    if (ifc.ready_o !== 1'b0) $display("FAIL reset_ready got %b want 0", ifc.ready_o);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (ifc.ready_o !== 1'b0) $display("FAIL release_ready got %b want 0", ifc.ready_o);
    else n_pass++;
    $display("reset: released, ready_o=%b", ifc.ready_o);
  endtask

  task automatic test_period();
    logic [65:0] blk;
    logic        exp_ready;
    int          data_out;
    logic [65:0] want2;
    blk      = {64'h0, 2'b01};
    data_out = 0;
    want2    = BIP_EN ? {64'he7b8896f18477690, 2'b10} : {64'hffb8896f00477690, 2'b10};
    for (int i = 0; i <= GAP + 1; i++) begin
      ifc.valid_i = 1'b1;
      ifc.block_i = blk;
      #1;
      exp_ready = !m_pending;
      n_checks++;
      if (ifc.ready_o !== exp_ready) $display("FAIL period_ready slot %0d got %b want %b", i, ifc.ready_o, exp_ready);
      else n_pass++;
      model_step(1'b1, blk);
      @(posedge clk); #1;
      n_checks++;
      if ({ifc.valid_o, ifc.am_v_o, ifc.block_o} !== {exp_valid, exp_am, exp_blk})
        $display("FAIL period_out slot %0d got v=%b am=%b blk=%h want v=%b am=%b blk=%h",
                 i, ifc.valid_o, ifc.am_v_o, ifc.block_o, exp_valid, exp_am, exp_blk);
      else n_pass++;
      if (ifc.valid_o && !ifc.am_v_o) data_out++;
      if (i == 0) begin
        n_checks++;
        if ({ifc.am_v_o, ifc.block_o} !== {1'b1, 64'hffb8896f00477690, 2'b10})
          $display("FAIL first_marker got am=%b blk=%h want am=1 blk=%h", ifc.am_v_o, ifc.block_o, {64'hffb8896f00477690, 2'b10});
        else n_pass++;
        $display("period: first marker blk=%h am=%b", ifc.block_o, ifc.am_v_o);
      end
      if (i == GAP + 1) begin
        n_checks++;
        if (exp_ready !== 1'b0 || ifc.am_v_o !== 1'b1 || ifc.block_o !== want2)
          $display("FAIL second_marker got am=%b blk=%h want am=1 blk=%h", ifc.am_v_o, ifc.block_o, want2);
        else n_pass++;
        n_checks++;
        if (data_out !== GAP) $display("FAIL period_data_count got %0d want %0d", data_out, GAP);
        else n_pass++;
        $display("period: second marker blk=%h after %0d data blocks", ifc.block_o, data_out);
      end
    end
  endtask

  task automatic test_random_gaps();
    logic        v;
    logic [65:0] blk;
    logic        exp_ready;
    int          obs_data;
    int          markers;
    obs_data = 0;   // previous test ended on a marker
    markers  = 0;
    for (int i = 0; i < 20500; i++) begin
      v   = ($urandom_range(0, 5) != 0);
      blk = rand_blk();
      ifc.valid_i = v;
      ifc.block_i = blk;
      #1;
      exp_ready = !m_pending;
      n_checks++;
      if (ifc.ready_o !== exp_ready) $display("FAIL gaps_ready cyc %0d got %b want %b", i, ifc.ready_o, exp_ready);
      else n_pass++;
      model_step(v, blk);
      @(posedge clk); #1;
      n_checks++;
      if ({ifc.valid_o, ifc.am_v_o, ifc.block_o} !== {exp_valid, exp_am, exp_blk})
        $display("FAIL gaps_out cyc %0d got v=%b am=%b blk=%h want v=%b am=%b blk=%h",
                 i, ifc.valid_o, ifc.am_v_o, ifc.block_o, exp_valid, exp_am, exp_blk);
      else n_pass++;
      if (ifc.valid_o && !ifc.am_v_o) obs_data++;
      if (ifc.valid_o && ifc.am_v_o) begin
        n_checks++;
        if (obs_data !== GAP) $display("FAIL gaps_spacing got %0d want %0d", obs_data, GAP);
        else n_pass++;
        $display("gaps: marker at cyc %0d blk=%h after %0d data blocks", i, ifc.block_o, obs_data);
        obs_data = 0;
        markers++;
      end
    end
    n_checks++;
    if (markers < 1) $display("FAIL gaps_marker_seen got %0d want >=1", markers);
    else n_pass++;
  endtask

  task automatic test_reset_mid_gap();
    logic [65:0] blk;
    logic        exp_ready;
    for (int i = 0; i < 8000; i++) begin
      blk = rand_blk();
      ifc.valid_i = 1'b1;
      ifc.block_i = blk;
      #1;
      exp_ready = !m_pending;
      n_checks++;
      if (ifc.ready_o !== exp_ready) $display("FAIL mid_ready cyc %0d got %b want %b", i, ifc.ready_o, exp_ready);
      else n_pass++;
      model_step(1'b1, blk);
      @(posedge clk); #1;
      n_checks++;
      if ({ifc.valid_o, ifc.am_v_o, ifc.block_o} !== {exp_valid, exp_am, exp_blk})
        $display("FAIL mid_out cyc %0d got v=%b am=%b blk=%h want v=%b am=%b blk=%h",
                 i, ifc.valid_o, ifc.am_v_o, ifc.block_o, exp_valid, exp_am, exp_blk);
      else n_pass++;
    end
    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({ifc.valid_o, ifc.am_v_o, ifc.block_o, ifc.ready_o} !== 69'h0)
      $display("FAIL async_clear got v=%b am=%b blk=%h rdy=%b want 0", ifc.valid_o, ifc.am_v_o, ifc.block_o, ifc.ready_o);
    else n_pass++;
    $display("mid_reset: outputs after async reset blk=%h", ifc.block_o);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    // Marker slot with valid_i low: the marker must be deferred.
    for (int i = 0; i < 3; i++) begin
      ifc.valid_i = 1'b0;
      ifc.block_i = rand_blk();
      #1;
      n_checks++;
      if (ifc.ready_o !== 1'b0) $display("FAIL defer_ready cyc %0d got %b want 0", i, ifc.ready_o);
      else n_pass++;
      model_step(1'b0, ifc.block_i);
      @(posedge clk); #1;
      n_checks++;
      if ({ifc.valid_o, ifc.am_v_o, ifc.block_o} !== {exp_valid, exp_am, exp_blk})
        $display("FAIL defer_out cyc %0d got v=%b am=%b blk=%h want v=%b am=%b blk=%h",
                 i, ifc.valid_o, ifc.am_v_o, ifc.block_o, exp_valid, exp_am, exp_blk);
      else n_pass++;
    end
    blk = rand_blk();
    ifc.valid_i = 1'b1;
    ifc.block_i = blk;
    #1;
    model_step(1'b1, blk);
    @(posedge clk); #1;
    n_checks++;
    if ({ifc.valid_o, ifc.am_v_o, ifc.block_o} !== {1'b1, 1'b1, 64'hffb8896f00477690, 2'b10})
      $display("FAIL post_reset_marker got v=%b am=%b blk=%h want marker bip 00/ff", ifc.valid_o, ifc.am_v_o, ifc.block_o);
    else n_pass++;
    $display("mid_reset: marker after reset blk=%h", ifc.block_o);
    ifc.valid_i = 1'b0;
  endtask

  task automatic test_lane2();
    logic [65:0] blk;
    logic [65:0] want;
    want = mk_marker(2, 8'h00);
    ifc2.valid_i = 1'b1;
    ifc2.block_i = rand_blk();
    rst2 = 1'b0;
    #1;
    n_checks++;
    if (ifc2.ready_o !== 1'b0) $display("FAIL lane2_ready got %b want 0", ifc2.ready_o);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({ifc2.valid_o, ifc2.am_v_o, ifc2.block_o} !== {1'b1, 1'b1, want})
      $display("FAIL lane2_marker got am=%b blk=%h want am=1 blk=%h", ifc2.am_v_o, ifc2.block_o, want);
    else n_pass++;
    $display("lane2: marker blk=%h", ifc2.block_o);
    blk = rand_blk();
    ifc2.block_i = blk;
    #1;
    n_checks++;
    if (ifc2.ready_o !== 1'b1) $display("FAIL lane2_ready_data got %b want 1", ifc2.ready_o);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({ifc2.valid_o, ifc2.am_v_o, ifc2.block_o} !== {1'b1, 1'b0, blk})
      $display("FAIL lane2_data got am=%b blk=%h want am=0 blk=%h", ifc2.am_v_o, ifc2.block_o, blk);
    else n_pass++;
    $display("lane2: data blk=%h", ifc2.block_o);
    ifc2.valid_i = 1'b0;
  endtask

  initial begin
    rst2         = 1'b1;
    ifc2.valid_i = 1'b0;
    ifc2.block_i = '0;
    test_reset();
    test_period();
    test_random_gaps();
    test_reset_mid_gap();
    test_lane2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
